// File: rtl/df_seq_mux.sv
// Sequenced operand mux: walks enabled channels in ascending order and streams them over valid/ready.
// Define DF_SEQ_MUX_BIAS_EN to append a fixed-point 1.0 bias beat after the channel beats.
module df_seq_mux #(
  parameter int DATA_WIDTH = 16,
  parameter int N_CH       = 7,
  parameter int SEL_W      = 3,
  parameter int FRAC_BITS  = 12
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [N_CH-1:0]              ch_mask,
  input  logic [N_CH*DATA_WIDTH-1:0]   data_in,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        data_o,
  output logic [SEL_W-1:0]             sel_o,
  output logic                         valid_o,
  output logic                         last_o,
  output logic                         busy,
  output logic                         done
);

  // state | meaning
  // IDLE  | waiting for start
  // SEND  | presenting a channel beat
  // BIAS  | presenting the 1.0 bias beat
  // FIN   | one-cycle done pulse
  typedef enum logic [1:0] {IDLE, SEND, BIAS, FIN} state_t;

`ifdef DF_SEQ_MUX_BIAS_EN
  localparam bit BIAS_EN = 1'b1;
`else
  localparam bit BIAS_EN = 1'b0;
`endif

  localparam logic [DATA_WIDTH-1:0] BIAS_WORD = DATA_WIDTH'(1) << FRAC_BITS;

  state_t                  state_q, state_d;
  logic [N_CH-1:0]         mask_q, mask_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic                    valid_q, valid_d;
  logic                    last_q, last_d;

  logic                    load_en;
  logic [N_CH-1:0]         src_mask;
  logic [N_CH-1:0]         rest_mask;
  logic [SEL_W-1:0]        low_idx;
  int                      low_int;

  function automatic logic [SEL_W-1:0] lowest(input logic [N_CH-1:0] m);
    lowest = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (m[i]) lowest = SEL_W'(i);
    end
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      mask_q  <= '0;
      data_q  <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    data_d    = data_q;
    sel_d     = sel_q;
    valid_d   = valid_q;
    last_d    = last_q;
    load_en   = 1'b0;
    src_mask  = mask_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          src_mask = ch_mask;
          load_en  = 1'b1;
        end
      end
      SEND: begin
        // The remaining mask still holds the bit of the beat on the wire until it transfers.
        if (valid_q && out_ready) begin
          src_mask = mask_q & ~(N_CH'(1) << sel_q);
          load_en  = 1'b1;
        end
      end
      BIAS: begin
        if (valid_q && out_ready) begin
          state_d = FIN;
          valid_d = 1'b0;
          last_d  = 1'b0;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    low_idx   = lowest(src_mask);
    low_int   = int'(low_idx);
    rest_mask = src_mask & ~(N_CH'(1) << low_idx);

    if (load_en) begin
      mask_d = src_mask;
      if (|src_mask) begin
        state_d = SEND;
        data_d  = data_in[low_int*DATA_WIDTH +: DATA_WIDTH];
        sel_d   = low_idx;
        valid_d = 1'b1;
        last_d  = !BIAS_EN && (rest_mask == '0);
      end else if (BIAS_EN) begin
        state_d = BIAS;
        data_d  = BIAS_WORD;
        sel_d   = SEL_W'(N_CH);
        valid_d = 1'b1;
        last_d  = 1'b1;
      end else begin
        state_d = FIN;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    end
  end

  always_comb begin
    data_o  = data_q;
    sel_o   = sel_q;
    valid_o = valid_q;
    last_o  = last_q;
    busy    = (state_q != IDLE);
    done    = (state_q == FIN);
  end

endmodule
